// File: rtl/prime_pkg.sv
// Shared types and limits for the sequential prime checker.
package prime_pkg;

  // Supported operand widths for prime_checker_seq
  localparam int unsigned MIN_WIDTH = 3;
  localparam int unsigned MAX_WIDTH = 32;

  // Controller states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    DIV  = 3'd2,
    EVAL = 3'd3,
    DONE = 3'd4
  } prime_state_t;

endpackage

// File: rtl/mod_unit.sv
// Restoring-remainder unit: dividend mod divisor, one quotient bit per cycle, MSB first.
// The first bit is folded into the load edge, so rdy rises WIDTH edges after a cycle
// in which load was asserted. rdy stays high whenever no remainder is in flight.
module mod_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             rdy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] cur_rem;
  logic [WIDTH-1:0] cur_div;
  logic             cur_bit;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;

  // One restoring step on the current partial remainder (zero on load)
  always_comb begin
    cur_rem = load ? '0 : rem_q;
    cur_bit = load ? dividend[WIDTH-1] : sh_q[WIDTH-1];
    cur_div = load ? divisor : div_q;
    // Partial remainder < divisor, so the shifted trial needs one extra bit
    trial   = {cur_rem, cur_bit};
    if (trial >= {1'b0, cur_div}) begin
      rem_step = WIDTH'(trial - {1'b0, cur_div});
    end else begin
      rem_step = trial[WIDTH-1:0];
    end
  end

  // Next-state: start a new division on load, otherwise step until the count drains
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    div_d = div_q;
    rem_d = rem_q;
    if (load) begin
      sh_d  = dividend << 1;
      div_d = divisor;
      cnt_d = CW'(WIDTH - 1);
      rem_d = rem_step;
    end else if (cnt_q != '0) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CW'(1);
      rem_d = rem_step;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
      div_q <= '0;
      rem_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      div_q <= div_d;
      rem_q <= rem_d;
    end
  end

  assign rem = rem_q;
  assign rdy = (cnt_q == '0);

endmodule

// File: rtl/prime_checker_seq.sv
// Sequential trial-division primality tester with a start/done handshake.
// Optional feature macro: PRIME_ODD_SKIP_EN (divisors 2, 3, 5, 7, ... instead of 2, 3, 4, ...).
module prime_checker_seq
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             prime
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("prime_checker_seq: WIDTH out of range");
  end

  prime_state_t       state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               prime_q, prime_d;

  logic               load;
  logic [WIDTH-1:0]   rem;
  logic               rdy;
  logic [WIDTH-1:0]   d_next;
  logic [2*WIDTH-1:0] d_next_sq;
  logic               past_root;

`ifdef PRIME_ODD_SKIP_EN
  // After 2, only odd candidates can be the smallest factor
  assign d_next = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
`else
  assign d_next = d_q + WIDTH'(1);
`endif

  // Square at double width so n = 2^WIDTH-1 cannot overflow the compare
  always_comb begin
    d_next_sq = {{WIDTH{1'b0}}, d_next} * {{WIDTH{1'b0}}, d_next};
    past_root = d_next_sq > {{WIDTH{1'b0}}, n_q};
  end

  mod_unit #(
    .WIDTH (WIDTH)
  ) u_mod (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dividend (n_q),
    .divisor  (d_d),
    .rem      (rem),
    .rdy      (rdy)
  );

  // Controller next-state and divisor sequencing
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    prime_d = prime_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d     = n;
          prime_d = 1'b0;
          state_d = INIT;
        end else begin
          state_d = IDLE;
        end
      end
      INIT: begin
        if (n_q < WIDTH'(2)) begin
          prime_d = 1'b0;
          state_d = DONE;
        end else if (n_q < WIDTH'(4)) begin
          prime_d = 1'b1;
          state_d = DONE;
        end else begin
          d_d     = WIDTH'(2);
          load    = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (rdy) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (rem == '0) begin
          prime_d = 1'b0;
          state_d = DONE;
        end else if (past_root) begin
          prime_d = 1'b1;
          state_d = DONE;
        end else begin
          d_d     = d_next;
          load    = 1'b1;
          state_d = DIV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      prime_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      prime_q <= prime_d;
    end
  end

  assign busy  = (state_q == INIT) || (state_q == DIV) || (state_q == EVAL);
  assign done  = (state_q == DONE);
  assign prime = prime_q;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Bench for prime_checker_seq: a WIDTH=3 instance for the legacy truth table and a
// WIDTH=8 instance for latency, handshake, reset and random operands.
module tb_prime_checker_seq;

`ifdef PRIME_ODD_SKIP_EN
  localparam bit OddSkip = 1'b1;
`else
  localparam bit OddSkip = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start3 = 1'b0, start8 = 1'b0;
  logic [2:0] n3 = '0;
  logic [7:0] n8 = '0;
  logic       busy3, done3, prime3;
  logic       busy8, done8, prime8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prime_checker_seq #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .n(n3),
    .busy(busy3), .done(done3), .prime(prime3)
  );

  prime_checker_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .n(n8),
    .busy(busy8), .done(done8), .prime(prime8)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain trial division
  function automatic bit ref_prime(input int unsigned v);
    if (v < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference latency: divisors tested are the sequence members up to the smallest
  // factor (composite) or up to floor(sqrt(v)) (prime).
  function automatic int ref_lat(input int unsigned v, input int w);
    int unsigned m;
    int unsigned r;
    int          cnt;
    if (v < 4) return 1;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    m = r;
    for (int unsigned d = 2; d <= r; d++) begin
      if (v % d == 0) begin
        m = d;
        break;
      end
    end
    cnt = OddSkip ? int'(1 + (m - 1) / 2) : int'(m - 1);
    return 1 + cnt * (w + 1);
  endfunction

  // Present an operand; returns 1ns after the accepting edge
  task automatic launch(input bit w8, input logic [7:0] val);
    if (w8) begin
      start8 = 1'b1;
      n8     = val;
    end else begin
      start3 = 1'b1;
      n3     = val[2:0];
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start3 = 1'b0;
  endtask

  // Count edges after the accepting edge until done is seen; -1 on timeout
  task automatic wait_done(input bit w8, input int already, output int lat);
    lat = -1;
    for (int c = already + 1; c <= already + 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      if ((w8 ? done8 : done3) === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [7:0]  tbl3;
    logic [7:0]  dir_n   [5];
    int          dir_lat [5];
    bit          dir_pr  [5];
    logic [7:0]  rv;

    tbl3 = 8'b1010_1100;
    dir_n   = '{8'd7, 8'd9, 8'd25, 8'd251, 8'd255};
    dir_pr  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    if (OddSkip) dir_lat = '{10, 19, 28, 73, 19};
    else         dir_lat = '{10, 19, 37, 127, 19};

    // Reset state
    #2;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_prime8", prime8, 0);
    check("rst_busy3", busy3, 0);
    check("rst_done3", done3, 0);
    @(negedge clk);
    rst = 1'b0;

    // Legacy 3-bit truth table
    for (int v = 0; v < 8; v++) begin
      launch(1'b0, 8'(v));
      wait_done(1'b0, 0, lat);
      check($sformatf("w3_lat_%0d", v), lat, ref_lat(v, 3));
      check($sformatf("w3_prime_%0d", v), prime3, tbl3[v]);
    end

    // Directed 8-bit operands with known latencies
    for (int i = 0; i < 5; i++) begin
      launch(1'b1, dir_n[i]);
      wait_done(1'b1, 0, lat);
      check($sformatf("dir_lat_%0d", dir_n[i]), lat, dir_lat[i]);
      check($sformatf("dir_prime_%0d", dir_n[i]), prime8, dir_pr[i]);
    end

    // start while busy is ignored
    launch(1'b1, 8'd7);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("ign_busy", busy8, 1);
    start8 = 1'b1;
    n8     = 8'd4;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n8     = 8'hAA;
    wait_done(1'b1, 3, lat);
    check("ign_lat", lat, 10);
    check("ign_prime", prime8, 1);

    // Back-to-back: start held in the done cycle
    launch(1'b1, 8'd9);
    wait_done(1'b1, 0, lat);
    check("b2b_first_lat", lat, 19);
    launch(1'b1, 8'd13);
    @(negedge clk);
    check("b2b_busy", busy8, 1);
    check("b2b_done", done8, 0);
    check("b2b_prime_clr", prime8, 0);
    wait_done(1'b1, 0, lat);
    check("b2b_lat", lat, ref_lat(13, 8));
    check("b2b_prime", prime8, 1);

    // Result held after done
    repeat (3) @(negedge clk);
    check("hold_prime", prime8, 1);
    check("hold_done", done8, 0);
    check("hold_busy", busy8, 0);

    // Random operands against the reference
    for (int i = 0; i < 16; i++) begin
      rv = 8'($urandom_range(0, 255));
      launch(1'b1, rv);
      wait_done(1'b1, 0, lat);
      check($sformatf("rnd_lat_%0d", rv), lat, ref_lat(rv, 8));
      check($sformatf("rnd_prime_%0d", rv), prime8, ref_prime(rv));
    end

    // Reset mid-division
    launch(1'b1, 8'd251);
    repeat (3) @(negedge clk);
    check("mid_busy_pre", busy8, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_prime", prime8, 0);
    @(negedge clk);
    rst = 1'b0;
    launch(1'b1, 8'd2);
    wait_done(1'b1, 0, lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_prime", prime8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
